// File: rtl/i2c_temp_responder.sv
// I2C target emulating the board temperature sensor. SCL/SDA are oversampled
// on clk; START/STOP, address and data bytes are decoded and SDA is driven
// open-drain for ACKs and read data. Pointer 0x00 returns a coherent 16-bit
// temperature snapshot, pointer 0x03 is a read/write configuration byte.
module i2c_temp_responder #(
    parameter logic [6:0] ADDR = 7'h4B
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCL,
    inout  wire         SDA,
    input  logic [15:0] temp_in,
    output logic [7:0]  config_reg,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_BYTE, ST_WR_ACK, ST_RD_BYTE, ST_RD_ACK
    } state_t;

    state_t      state, state_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  pointer, pointer_n;
    logic [7:0]  config_n;
    logic [15:0] shadow, shadow_n;
    logic        sda_low, sda_low_n;
    logic        busy_n;
    logic        byte_sel, byte_sel_n;
    logic        first_byte, first_byte_n;
    logic        rw, rw_n;
    logic        ack_ok, ack_ok_n;
    logic [7:0]  tx_byte;

    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;
    logic scl_rise, scl_fall, start_det, stop_det;

    // Byte presented on a read for the current pointer and byte index
    function automatic logic [7:0] rd_source(input logic [7:0] ptr, input logic sel,
                                             input logic [15:0] shd, input logic [7:0] cfg);
        if (ptr == 8'h00)
            return sel ? shd[7:0] : shd[15:8];
        else if (ptr == 8'h03)
            return cfg;
        else
            return 8'h00;
    endfunction

    // Open-drain output: only ever pull low or release
    assign SDA = sda_low ? 1'b0 : 1'bz;

    // Edge and bus-condition detection from the synchronized samples
    assign scl_rise  =  scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 &  scl_p2;
    assign start_det = ~sda_p1 &  sda_p2 & scl_p1 & scl_p2;
    assign stop_det  =  sda_p1 & ~sda_p2 & scl_p1 & scl_p2;

    // Two-flop synchronizers plus history flop; idle bus level is high
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= SCL;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= SDA;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    // Protocol state and register file update
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= 4'd0;
            shift      <= 8'h00;
            pointer    <= 8'h00;
            config_reg <= 8'h00;
            shadow     <= 16'h0000;
            sda_low    <= 1'b0;
            busy       <= 1'b0;
            byte_sel   <= 1'b0;
            first_byte <= 1'b0;
            rw         <= 1'b0;
            ack_ok     <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            pointer    <= pointer_n;
            config_reg <= config_n;
            shadow     <= shadow_n;
            sda_low    <= sda_low_n;
            busy       <= busy_n;
            byte_sel   <= byte_sel_n;
            first_byte <= first_byte_n;
            rw         <= rw_n;
            ack_ok     <= ack_ok_n;
        end
    end

    // Next-state logic; START/STOP override any SCL edge seen in the same clk
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        pointer_n    = pointer;
        config_n     = config_reg;
        shadow_n     = shadow;
        sda_low_n    = sda_low;
        busy_n       = busy;
        byte_sel_n   = byte_sel;
        first_byte_n = first_byte;
        rw_n         = rw;
        ack_ok_n     = ack_ok;
        tx_byte      = 8'h00;

        if (start_det) begin
            state_n   = ST_ADDR;
            bit_cnt_n = 4'd0;
            sda_low_n = 1'b0;
        end else if (stop_det) begin
            state_n   = ST_IDLE;
            sda_low_n = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda_p1};
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = 4'd0;
                            if (shift[6:0] == ADDR) begin
                                state_n      = ST_ADDR_ACK;
                                busy_n       = 1'b1;
                                rw_n         = sda_p1;
                                byte_sel_n   = 1'b0;
                                first_byte_n = 1'b1;
                            end else begin
                                state_n = ST_IDLE;
                                busy_n  = 1'b0;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd0) begin
                            sda_low_n = 1'b1;
                            bit_cnt_n = 4'd1;
                        end else if (rw) begin
                            // Snapshot taken here so both temperature bytes match
                            shadow_n  = temp_in;
                            tx_byte   = rd_source(pointer, byte_sel, temp_in, config_reg);
                            sda_low_n = ~tx_byte[7];
                            shift_n   = {tx_byte[6:0], 1'b0};
                            bit_cnt_n = 4'd1;
                            state_n   = ST_RD_BYTE;
                        end else begin
                            sda_low_n = 1'b0;
                            bit_cnt_n = 4'd0;
                            state_n   = ST_WR_BYTE;
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda_p1};
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n    = 4'd0;
                            first_byte_n = 1'b0;
                            state_n      = ST_WR_ACK;
                            if (first_byte) begin
                                pointer_n = {shift[6:0], sda_p1};
                                ack_ok_n  = 1'b1;
                            end else if (pointer == 8'h03) begin
                                config_n = {shift[6:0], sda_p1};
                                ack_ok_n = 1'b1;
                            end else begin
                                ack_ok_n = 1'b0;
                            end
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd0) begin
                            sda_low_n = ack_ok;
                            bit_cnt_n = 4'd1;
                        end else begin
                            sda_low_n = 1'b0;
                            bit_cnt_n = 4'd0;
                            state_n   = ST_WR_BYTE;
                        end
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_low_n = 1'b0;
                            bit_cnt_n = 4'd0;
                            state_n   = ST_RD_ACK;
                        end else begin
                            sda_low_n = ~shift[7];
                            shift_n   = {shift[6:0], 1'b0};
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_p1) begin
                            state_n = ST_IDLE;
                            busy_n  = 1'b0;
                        end else begin
                            byte_sel_n = ~byte_sel;
                            bit_cnt_n  = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        tx_byte   = rd_source(pointer, byte_sel, shadow, config_reg);
                        sda_low_n = ~tx_byte[7];
                        shift_n   = {tx_byte[6:0], 1'b0};
                        state_n   = ST_RD_BYTE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule
